// File: rtl/ecc_scrub_controller.sv
// rtl/ecc_scrub_controller.sv - host/scrub arbiter for a 39-bit SECDED-protected single-port memory
// Holds the Hamming encoder, the correction_detection decoder and the sequencing FSM.

module ecc_encoder (
   input  logic [31:0] data,
   output logic [6:0]  parity
);
   // Data fills the non-power-of-two positions 3..38; check bit j covers every position with bit j set.
   logic [5:0] chk;

   always_comb begin
      logic [4:0] k;
      chk = '0;
      k   = '0;
      for (int pos = 3; pos < 39; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (data[k]) chk = chk ^ pos[5:0];
            k = k + 5'd1;
         end
      end
   end

   assign parity = {^{chk, data}, chk};
endmodule

module correction_detection (
   input  logic [38:0] code,
   output logic [31:0] data,
   output logic        single_error,
   output logic        double_error
);
   logic [5:0] syn;
   logic       odd;

   always_comb begin
      logic [4:0] k;
      syn = code[37:32];
      k   = '0;
      for (int pos = 3; pos < 39; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (code[k]) syn = syn ^ pos[5:0];
            k = k + 5'd1;
         end
      end
   end

   // Odd overall parity means one flipped bit, unless the syndrome points past the codeword.
   assign odd          = ^code;
   assign single_error = odd && (syn <= 6'd38);
   assign double_error = (!odd && (syn != 6'd0)) || (odd && (syn > 6'd38));

   always_comb begin
      logic [4:0] k;
      data = code[31:0];
      k    = '0;
      for (int pos = 3; pos < 39; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (single_error && (syn == pos[5:0])) data[k] = ~code[k];
            k = k + 5'd1;
         end
      end
   end
endmodule

module ecc_scrub_controller #(
   parameter int ADDR_W         = 10,
   parameter int SCRUB_INTERVAL = 256,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scrub_en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_serr,
   output logic              resp_derr,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [38:0]       mem_wdata,
   input  logic [38:0]       mem_rdata,
   output logic [CNT_W-1:0]  serr_cnt,
   output logic [CNT_W-1:0]  derr_cnt,
   output logic [ADDR_W-1:0] last_err_addr,
   output logic [ADDR_W-1:0] scrub_addr
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WRITE    = 3'd1;
   localparam logic [2:0] RD_ISSUE = 3'd2;
   localparam logic [2:0] RD_WAIT  = 3'd3;
   localparam logic [2:0] CHECK    = 3'd4;
   localparam logic [2:0] WBACK    = 3'd5;

   localparam logic [15:0] TIMER_LAST = 16'(SCRUB_INTERVAL - 1);

   logic [2:0]        state;
   logic              op_host;
   logic [ADDR_W-1:0] op_addr;
   logic [31:0]       op_wdata;
   logic [38:0]       rd_word;
   logic [15:0]       timer;

   logic [31:0] dec_data;
   logic        dec_serr;
   logic        dec_derr;
   logic [31:0] enc_in;
   logic [6:0]  enc_par;
   logic        accept;
   logic        host_check;

   correction_detection u_dec (
      .code         (rd_word),
      .data         (dec_data),
      .single_error (dec_serr),
      .double_error (dec_derr)
   );

   // One encoder serves both host writes and the writeback of the still-registered corrected word.
   assign enc_in = (state == WBACK) ? dec_data : op_wdata;

   ecc_encoder u_enc (
      .data   (enc_in),
      .parity (enc_par)
   );

   assign req_ready  = (state == IDLE);
   assign accept     = req_valid && req_ready;
   assign host_check = (state == CHECK) && op_host;

   assign mem_en    = (state == WRITE) || (state == RD_ISSUE) || (state == WBACK);
   assign mem_we    = (state == WRITE) || (state == WBACK);
   assign mem_addr  = op_addr;
   assign mem_wdata = mem_we ? {enc_par, enc_in} : 39'd0;

   assign resp_valid = (state == WRITE) || host_check;
   assign resp_data  = host_check ? dec_data : 32'd0;
   assign resp_serr  = host_check && dec_serr;
   assign resp_derr  = host_check && dec_derr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_host       <= 1'b0;
         op_addr       <= '0;
         op_wdata      <= '0;
         rd_word       <= '0;
         timer         <= '0;
         serr_cnt      <= '0;
         derr_cnt      <= '0;
         last_err_addr <= '0;
         scrub_addr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_addr  <= req_addr;
                  op_wdata <= req_wdata;
                  op_host  <= 1'b1;
                  state    <= req_we ? WRITE : RD_ISSUE;
               end else if (scrub_en) begin
                  if (timer == TIMER_LAST) begin
                     op_addr <= scrub_addr;
                     op_host <= 1'b0;
                     timer   <= '0;
                     state   <= RD_ISSUE;
                  end else begin
                     timer <= timer + 16'd1;
                  end
               end
            end
            WRITE:    state <= IDLE;
            RD_ISSUE: state <= RD_WAIT;
            RD_WAIT: begin
               rd_word <= mem_rdata;
               state   <= CHECK;
            end
            CHECK: begin
               if (!op_host) scrub_addr <= scrub_addr + 1'b1;
               if (dec_serr) begin
                  if (serr_cnt != '1) serr_cnt <= serr_cnt + 1'b1;
                  last_err_addr <= op_addr;
                  state         <= WBACK;
               end else if (dec_derr) begin
                  if (derr_cnt != '1) derr_cnt <= derr_cnt + 1'b1;
                  last_err_addr <= op_addr;
                  state         <= IDLE;
               end else begin
                  state <= IDLE;
               end
            end
            WBACK:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ecc_scrub_controller.sv
// tb/tb_ecc_scrub_controller.sv - self-checking bench for ecc_scrub_controller with a behavioural memory model
// Expected values come from a shadow data store plus injected flip counts.

module tb_ecc_scrub_controller;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int SI     = 4;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              scrub_en = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              req_ready;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              resp_serr;
   logic              resp_derr;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [38:0]       mem_wdata;
   logic [38:0]       mem_rdata;
   logic [CNT_W-1:0]  serr_cnt;
   logic [CNT_W-1:0]  derr_cnt;
   logic [ADDR_W-1:0] last_err_addr;
   logic [ADDR_W-1:0] scrub_addr;

   ecc_scrub_controller #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_serr(resp_serr), .resp_derr(resp_derr),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .serr_cnt(serr_cnt), .derr_cnt(derr_cnt), .last_err_addr(last_err_addr), .scrub_addr(scrub_addr)
   );

   always #5 clk = ~clk;

   typedef struct { int c; logic [ADDR_W-1:0] a; } rd_t;

   logic [38:0]       mem [DEPTH];
   logic              pre_we = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [38:0]       pre_data = '0;
   int                cyc = 0;
   int                wr_cnt = 0;
   int                resp_cnt = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   logic [38:0]       last_wr_data = '0;
   rd_t               rd_log[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (resp_valid) resp_cnt <= resp_cnt + 1;
      if (pre_we) mem[pre_addr] <= pre_data;
      if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 1;
         last_wr_addr  <= mem_addr;
         last_wr_data  <= mem_wdata;
      end
      if (mem_en && !mem_we) begin
         mem_rdata <= mem[mem_addr];
         rd_log.push_back('{c: cyc, a: mem_addr});
      end
   end

   logic [31:0]       shadow [DEPTH];
   int                m_serr = 0;
   int                m_derr = 0;
   logic [ADDR_W-1:0] m_last = '0;
   int                dpos [32];
   int                n_checks = 0;
   int                n_pass = 0;

   typedef struct {
      bit                we;
      bit                pre;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [38:0]       flip;
      bit                e_serr;
      bit                e_derr;
   } vec_t;

   task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
   endtask

   // Check bit b is the parity of the data bits whose codeword position has bit b set.
   function automatic logic [6:0] tb_enc(input logic [31:0] d);
      logic [6:0] p;
      p = '0;
      for (int b = 0; b < 6; b++)
         for (int j = 0; j < 32; j++)
            if (((dpos[j] >> b) & 1) == 1) p[b] = p[b] ^ d[j];
      p[6] = ^{p[5:0], d};
      return p;
   endfunction

   function automatic logic [38:0] codeword(input logic [31:0] d);
      return {tb_enc(d), d};
   endfunction

   function automatic vec_t mkv(input bit we, input bit pre, input int a, input logic [31:0] d,
                                input logic [38:0] f, input bit s, input bit e);
      vec_t v;
      v.we = we; v.pre = pre; v.addr = ADDR_W'(a); v.data = d; v.flip = f; v.e_serr = s; v.e_derr = e;
      return v;
   endfunction

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [38:0] w);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = w;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   task automatic host_op(input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output bit s, output bit e,
                          output logic [38:0] ww);
      int g;
      lat = -1; rd = '0; s = 1'b0; e = 1'b0; ww = '0; g = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = c; rd = resp_data; s = resp_serr; e = resp_derr;
            ww = (mem_en && mem_we) ? mem_wdata : 39'd0;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          lat;
      int          wr0;
      logic [31:0] rd;
      bit          s;
      bit          e;
      logic [38:0] ww;
      if (v.pre) begin
         shadow[v.addr] = v.data;
         preload(v.addr, codeword(v.data) ^ v.flip);
      end
      wr0 = wr_cnt;
      host_op(v.we, v.addr, v.data, lat, rd, s, e, ww);
      if (v.we) begin
         shadow[v.addr] = v.data;
         check("wr_lat", idx, lat, 1);
         check("wr_ack", idx, rd, 0);
         check("wr_word", idx, ww, codeword(v.data));
         check("wr_cnt", idx, wr_cnt - wr0, 1);
      end else begin
         check("rd_lat", idx, lat, 3);
         if (!v.e_derr) check("rd_data", idx, rd, shadow[v.addr]);
         check("rd_serr", idx, s, v.e_serr);
         check("rd_derr", idx, e, v.e_derr);
         check("wb_cnt", idx, wr_cnt - wr0, v.e_serr ? 1 : 0);
         if (v.e_serr) begin
            check("wb_addr", idx, last_wr_addr, v.addr);
            check("wb_word", idx, last_wr_data, codeword(shadow[v.addr]));
            if (m_serr < CMAX) m_serr++;
            m_last = v.addr;
         end
         if (v.e_derr) begin
            if (m_derr < CMAX) m_derr++;
            m_last = v.addr;
         end
      end
      check("serr_cnt", idx, serr_cnt, m_serr);
      check("derr_cnt", idx, derr_cnt, m_derr);
      check("last_err", idx, last_err_addr, m_last);
   endtask

   vec_t tbl [12];

   initial begin
      int   k;
      int   g;
      int   n;
      int   b1;
      int   b2;
      int   c0;
      int   wr0;
      int   r0;
      int   lat;
      vec_t v;

      k = 0;
      for (int pos = 1; pos <= 38; pos++)
         if ($countones(pos) != 1) begin
            dpos[k] = pos;
            k++;
         end

      tbl[0]  = mkv(1, 0, 5,  32'hDEADBEEF, 39'h0,          0, 0);
      tbl[1]  = mkv(0, 0, 5,  32'hDEADBEEF, 39'h0,          0, 0);
      tbl[2]  = mkv(0, 1, 7,  32'h12345678, 39'h1,          1, 0);
      tbl[3]  = mkv(0, 0, 7,  32'h12345678, 39'h0,          0, 0);
      tbl[4]  = mkv(0, 1, 9,  32'hA5A55A5A, 39'h100008,     0, 1);
      tbl[5]  = mkv(0, 1, 3,  32'hFFFF0000, 39'h0800000000, 1, 0);
      tbl[6]  = mkv(0, 1, 12, 32'h00000001, 39'h4000000000, 1, 0);
      tbl[7]  = mkv(1, 0, 0,  32'hFFFFFFFF, 39'h0,          0, 0);
      tbl[8]  = mkv(0, 0, 0,  32'hFFFFFFFF, 39'h0,          0, 0);
      tbl[9]  = mkv(0, 1, 14, 32'hCAFEF00D, 39'h1080000000, 0, 1);
      tbl[10] = mkv(0, 1, 15, 32'h80000000, 39'h0080000000, 1, 0);
      tbl[11] = mkv(0, 1, 1,  32'h00000000, 39'h0300000000, 0, 1);

      for (int a = 0; a < DEPTH; a++) begin
         shadow[a] = '0;
         preload(ADDR_W'(a), codeword(32'd0));
      end
      #1;
      check("rst_ready", 0, req_ready, 1);
      check("rst_resp", 0, resp_valid, 0);
      check("rst_mem_en", 0, mem_en, 0);
      check("rst_mem_we", 0, mem_we, 0);
      check("rst_wdata", 0, mem_wdata, 0);
      check("rst_serr", 0, serr_cnt, 0);
      check("rst_derr", 0, derr_cnt, 0);
      check("rst_last", 0, last_err_addr, 0);
      check("rst_scrub", 0, scrub_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

      for (int i = 0; i < 40; i++) begin
         v = mkv($urandom_range(0, 2) == 0, 0, $urandom_range(0, DEPTH - 1), $urandom, 39'h0, 0, 0);
         if (!v.we) begin
            n  = $urandom_range(0, 2);
            b1 = $urandom_range(0, 38);
            b2 = (b1 + 1 + $urandom_range(0, 37)) % 39;
            v.pre = 1;
            if (n >= 1) v.flip = 39'd1 << b1;
            if (n == 2) v.flip = v.flip | (39'd1 << b2);
            v.e_serr = (n == 1);
            v.e_derr = (n == 2);
         end
         run_vec(v, 100 + i);
      end

      for (int i = 0; i < (1 << CNT_W); i++) begin
         v = mkv(0, 1, i % DEPTH, $urandom, 39'd1 << $urandom_range(0, 38), 1, 0);
         run_vec(v, 200 + i);
      end
      check("serr_sat", 0, serr_cnt, CMAX);

      for (int a = 0; a < DEPTH; a++) preload(ADDR_W'(a), codeword(shadow[a]));

      // Reset while the read is in RD_WAIT.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("mr_issue", 0, mem_en, 1);
      @(negedge clk);
      wr0 = wr_cnt;
      r0  = resp_cnt;
      #1 rst_n = 1'b0;
      #1;
      check("mr_mem_en", 0, mem_en, 0);
      check("mr_mem_we", 0, mem_we, 0);
      check("mr_ready", 0, req_ready, 1);
      check("mr_resp", 0, resp_valid, 0);
      check("mr_serr", 0, serr_cnt, 0);
      check("mr_derr", 0, derr_cnt, 0);
      check("mr_last", 0, last_err_addr, 0);
      check("mr_scrub", 0, scrub_addr, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_serr = 0; m_derr = 0; m_last = '0;
      repeat (6) @(negedge clk);
      check("mr_nowrite", 0, wr_cnt - wr0, 0);
      check("mr_noresp", 0, resp_cnt - r0, 0);

      // Background scrub with no host traffic.
      rd_log.delete();
      r0 = resp_cnt;
      @(negedge clk);
      c0 = cyc;
      scrub_en = 1'b1;
      g = 0;
      while (rd_log.size() < 18 && g < 400) begin
         @(negedge clk);
         g++;
      end
      check("scrub_n", 0, rd_log.size() >= 18, 1);
      if (rd_log.size() > 0) check("scrub_first", 0, rd_log[0].c - c0, SI);
      for (int i = 0; i < rd_log.size() && i < 18; i++) begin
         check("scrub_addr_seq", i, rd_log[i].a, i % DEPTH);
         if (i > 0) check("scrub_gap", i, rd_log[i].c - rd_log[i-1].c, SI + 3);
      end
      repeat (2) @(negedge clk);
      check("scrub_ptr", 0, scrub_addr, 18 % DEPTH);
      check("scrub_noresp", 0, resp_cnt - r0, 0);
      check("scrub_serr", 0, serr_cnt, 0);
      check("scrub_derr", 0, derr_cnt, 0);

      // Host request arrives in the cycle the interval timer expires.
      n = rd_log.size();
      g = 0;
      while (!(mem_en && !mem_we) && g < 30) begin
         @(negedge clk);
         g++;
      end
      repeat (SI + 2) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5;
      check("col_ready", 0, req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = c;
            check("col_data", 0, resp_data, shadow[5]);
            break;
         end
      end
      check("col_lat", 0, lat, 3);
      g = 0;
      while (rd_log.size() < n + 3 && g < 40) begin
         @(negedge clk);
         g++;
      end
      check("col_n", 0, rd_log.size() >= n + 3, 1);
      if (rd_log.size() >= n + 3) begin
         check("col_scrub0", 0, rd_log[n].a, n % DEPTH);
         check("col_host", 0, rd_log[n+1].a, 5);
         check("col_host_gap", 0, rd_log[n+1].c - rd_log[n].c, SI + 3);
         check("col_scrub1", 0, rd_log[n+2].a, (n + 1) % DEPTH);
         check("col_defer_gap", 0, rd_log[n+2].c - rd_log[n+1].c, 4);
      end
      scrub_en = 1'b0;
      repeat (8) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
